// File: rtl/fifo_rd_pkg.sv
// Shared types for the showahead-FIFO burst reader.
// State encoding and skid buffer depth.
package fifo_rd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    FLUSH = 2'd2
  } rd_state_e;

  localparam int SKID_DEPTH = 2;

endpackage

// File: rtl/stream_skid_buf.sv
// Two-entry register FIFO driving a valid/ready stream.
// Head entry is always mem0; payload is held stable while stalled.
module stream_skid_buf
  import fifo_rd_pkg::*;
#(
  parameter int WIDTH = 34
) (
  input  logic             clk_i,
  input  logic             arstn_i,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic [1:0]       count,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  logic [WIDTH-1:0] mem0;
  logic [WIDTH-1:0] mem1;
  logic             rd;
  logic [1:0]       wr_pos;

  assign out_valid = (count != 2'd0);
  assign out_data  = mem0;
  assign rd        = out_valid && out_ready;
  assign wr_pos    = rd ? count - 2'd1 : count;

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      mem0  <= '0;
      mem1  <= '0;
      count <= 2'd0;
    end else begin
      if (rd) mem0 <= mem1;
      // A write lands after the shift, so it may refill the head slot.
      if (wr_en) begin
        if (wr_pos == 2'd0) mem0 <= wr_data;
        else                mem1 <= wr_data;
      end
      count <= count + {1'b0, wr_en} - {1'b0, rd};
    end
  end

endmodule

// File: rtl/fifo_burst_reader.sv
// Drains a showahead FIFO as framed sop/eop bursts.
// Full bursts wait for BURST_LEN words; flush drains a remainder.
module fifo_burst_reader
  import fifo_rd_pkg::*;
#(
  parameter int DWIDTH    = 32,
  parameter int AWIDTH    = 4,
  parameter int BURST_LEN = 4
) (
  input  logic              clk_i,
  input  logic              arstn_i,
  input  logic [DWIDTH-1:0] fifo_q_i,
  input  logic              fifo_empty_i,
  input  logic [AWIDTH:0]   fifo_usedw_i,
  output logic              fifo_rdreq_o,
  input  logic              flush_i,
  output logic [DWIDTH-1:0] src_data_o,
  output logic              src_valid_o,
  input  logic              src_ready_i,
  output logic              src_sop_o,
  output logic              src_eop_o,
  output logic              busy_o
);

  localparam int PW = DWIDTH + 2;
  localparam logic [AWIDTH:0] BL = (AWIDTH+1)'(BURST_LEN);

  if (BURST_LEN < 1 || BURST_LEN > (1 << AWIDTH)) begin : g_bad_len
    $error("BURST_LEN must be in 1..2**AWIDTH");
  end

  rd_state_e       state;
  logic [AWIDTH:0] beat;
  logic [AWIDTH:0] len;
  logic            flush_pend;
  logic [1:0]      skid_cnt;
  logic            pop;
  logic            sop;
  logic            last;
  logic [PW-1:0]   head;

  // Pop depends only on registered state, never on src_ready_i.
  assign pop = (state != IDLE) && !fifo_empty_i
             && (skid_cnt < 2'(SKID_DEPTH));
  assign sop  = (beat == '0);
  assign last = (beat == len - 1'b1);

  assign fifo_rdreq_o = pop;
  assign busy_o = (state != IDLE) || (skid_cnt != 2'd0);

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state      <= IDLE;
      beat       <= '0;
      len        <= '0;
      flush_pend <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          beat <= '0;
          if (fifo_usedw_i >= BL) begin
            state <= BURST;
            len   <= BL;
          end else if (flush_pend && fifo_usedw_i != '0) begin
            state <= FLUSH;
            len   <= fifo_usedw_i;
          end else if (flush_pend) begin
            flush_pend <= 1'b0;
          end
        end
        BURST, FLUSH: begin
          if (pop) begin
            if (last) begin
              state <= IDLE;
              beat  <= '0;
              if (state == FLUSH) flush_pend <= 1'b0;
            end else begin
              beat <= beat + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
      // A new request outranks a same-cycle clear.
      if (flush_i) flush_pend <= 1'b1;
    end
  end

  stream_skid_buf #(
    .WIDTH(PW)
  ) u_skid (
    .clk_i    (clk_i),
    .arstn_i  (arstn_i),
    .wr_en    (pop),
    .wr_data  ({fifo_q_i, sop, last}),
    .count    (skid_cnt),
    .out_data (head),
    .out_valid(src_valid_o),
    .out_ready(src_ready_i)
  );

  assign src_data_o = head[PW-1:2];
  assign src_sop_o  = head[1];
  assign src_eop_o  = head[0];

endmodule
